// File: rtl/icb_pkg.sv
// ICB bus types, size codes and the response entry shared by the scratchpad slave and its FIFO.
package icb_pkg;

    localparam int ICB_AW = 32;
    localparam int ICB_DW = 32;
    localparam int ICB_MW = ICB_DW / 8;

    localparam logic [1:0] ICB_SIZE_B = 2'b00;
    localparam logic [1:0] ICB_SIZE_H = 2'b01;
    localparam logic [1:0] ICB_SIZE_W = 2'b10;

    typedef struct packed {
        logic              valid;
        logic [ICB_AW-1:0] addr;
        logic              read;
        logic [ICB_DW-1:0] wdata;
        logic [ICB_MW-1:0] wmask;
        logic [1:0]        size;
    } icb_cmd_m_t;

    typedef struct packed {
        logic ready;
    } icb_cmd_s_t;

    typedef struct packed {
        logic              valid;
        logic [ICB_DW-1:0] rdata;
        logic              err;
    } icb_rsp_s_t;

    typedef struct packed {
        logic ready;
    } icb_rsp_m_t;

    typedef struct packed {
        logic [ICB_DW-1:0] rdata;
        logic              err;
    } icb_rsp_entry_t;

    // Halfwords need an even address, words a 4-byte aligned one; bytes go anywhere.
    function automatic logic icb_misaligned(input logic [1:0] size, input logic [1:0] lsb);
        case (size)
            ICB_SIZE_H: return lsb[0];
            ICB_SIZE_W: return |lsb;
            default:    return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/icb_rsp_fifo.sv
// Synchronous circular FIFO of ICB response entries with an occupancy count.
module icb_rsp_fifo
    import icb_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           push,
    input  icb_rsp_entry_t din,
    input  logic           pop,
    output icb_rsp_entry_t head,
    output logic [CNT_W-1:0] count,
    output logic           empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    icb_rsp_entry_t   slots [DEPTH];
    logic [PTR_W-1:0] wptr;
    logic [PTR_W-1:0] rptr;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) wptr <= next_ptr(wptr);
            if (pop)  rptr <= next_ptr(rptr);
            if (push && !pop)      count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) slots[wptr] <= din;
    end

    assign head  = slots[rptr];
    assign empty = (count == '0);

endmodule

// File: rtl/icb_spm_slave.sv
// ICB slave scratchpad: byte-masked SRAM with a one-stage response path and in-order response FIFO.
// Define ICB_SPM_ERR_CHK_EN to enable address range/alignment checking and the sticky err_flag.
module icb_spm_slave
    import icb_pkg::*;
#(
    parameter int                    BUS_WIDTH      = 32,
    parameter int                    ADDR_WIDTH     = 32,
    parameter int                    DEPTH_WORDS    = 1024,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR      = 32'h1000_0000,
    parameter int                    RSP_FIFO_DEPTH = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  icb_cmd_m_t icb_cmd_m,
    output icb_cmd_s_t icb_cmd_s,
    output icb_rsp_s_t icb_rsp_s,
    input  icb_rsp_m_t icb_rsp_m,
    output logic       err_flag,
    input  logic       err_clr
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);
    localparam int BYTES = BUS_WIDTH / 8;
    localparam int CNT_W = $clog2(RSP_FIFO_DEPTH + 1);

    logic [BUS_WIDTH-1:0]  mem [DEPTH_WORDS];
    logic [ADDR_WIDTH-1:0] offset;
    logic [IDX_W-1:0]      idx;
    logic                  cmd_ready;
    logic                  fire;
    logic                  cmd_err;
    logic                  wr_en;

    logic                  s1_vld;
    logic                  s1_read;
    logic                  s1_err;
    logic [BUS_WIDTH-1:0]  rd_q;
    icb_rsp_entry_t        s1_entry;

    icb_rsp_entry_t        head;
    logic [CNT_W-1:0]      count;
    logic                  fifo_empty;
    logic                  push;
    logic                  pop;

    assign offset = icb_cmd_m.addr - BASE_ADDR;
    assign idx    = offset[IDX_W+1:2];

    // Ready looks only at registered occupancy, so it never depends on the response ready.
    assign cmd_ready       = (int'(count) + int'(s1_vld)) < RSP_FIFO_DEPTH;
    assign icb_cmd_s.ready = cmd_ready;
    assign fire            = icb_cmd_m.valid & cmd_ready;

`ifdef ICB_SPM_ERR_CHK_EN
    logic out_of_range;
    assign out_of_range = (icb_cmd_m.addr < BASE_ADDR) ||
                          (offset[ADDR_WIDTH-1:IDX_W+2] != '0);
    assign cmd_err = out_of_range | icb_misaligned(icb_cmd_m.size, icb_cmd_m.addr[1:0]);

    always_ff @(posedge clk) begin
        if (rst)                  err_flag <= 1'b0;
        else if (fire && cmd_err) err_flag <= 1'b1;
        else if (err_clr)         err_flag <= 1'b0;
    end
`else
    logic unused_cfg;
    assign cmd_err    = 1'b0;
    assign err_flag   = 1'b0;
    assign unused_cfg = ^{offset[ADDR_WIDTH-1:IDX_W+2], icb_cmd_m.size, err_clr};
`endif

    logic unused_lsb;
    assign unused_lsb = ^offset[1:0];

    // Stage T: SRAM write at the end of the accept cycle, synchronous read into rd_q
    assign wr_en = fire & ~icb_cmd_m.read & ~cmd_err & ~rst;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < BYTES; b++) begin
                if (icb_cmd_m.wmask[b]) mem[idx][8*b +: 8] <= icb_cmd_m.wdata[8*b +: 8];
            end
        end
        if (fire && icb_cmd_m.read) rd_q <= mem[idx];
    end

    always_ff @(posedge clk) begin
        if (rst) s1_vld <= 1'b0;
        else     s1_vld <= fire;
        s1_read <= icb_cmd_m.read;
        s1_err  <= cmd_err;
    end

    // Stage T+1: bypass s1 to the bus when the FIFO is empty, otherwise queue behind older responses
    assign s1_entry.rdata = (s1_read && !s1_err) ? rd_q : '0;
    assign s1_entry.err   = s1_err;

    assign pop  = ~fifo_empty & icb_rsp_m.ready;
    assign push = s1_vld & ~(fifo_empty & icb_rsp_m.ready);

    icb_rsp_fifo #(
        .DEPTH (RSP_FIFO_DEPTH),
        .CNT_W (CNT_W)
    ) u_rsp_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   (s1_entry),
        .pop   (pop),
        .head  (head),
        .count (count),
        .empty (fifo_empty)
    );

    always_comb begin
        icb_rsp_s = '0;
        if (!fifo_empty) begin
            icb_rsp_s.valid = 1'b1;
            icb_rsp_s.rdata = head.rdata;
            icb_rsp_s.err   = head.err;
        end else if (s1_vld) begin
            icb_rsp_s.valid = 1'b1;
            icb_rsp_s.rdata = s1_entry.rdata;
            icb_rsp_s.err   = s1_entry.err;
        end
    end

endmodule
